host_from_breakout: RTL and testbench
=====================================

// Module: host_from_breakout
// PURPOSE
//  Host-side receiver for the breakout serial status link. Oversamples the 3-wire link
//  (i_clk_s, i_d0_s, i_d1_s) in the host i_clk domain and recovers the breakout's port,
//  button and link-power words. Frames are delimited by idle gaps. Each complete frame is
//  presented as a parallel word with a 1-cycle valid strobe, plus frame-error and lock status.
// PARAMETERS
//  SYNC_STAGES   2    flip-flop stages per input synchroniser (>=2)
//  IDLE_CYCLES   16   i_clk cycles with i_clk_s high and no edge that mark a frame gap
//  LOSS_CYCLES   4096 i_clk cycles with no i_clk_s rising edge before o_locked drops
// PORTS
//  i_clk        in   1  host system clock; all logic in this domain
//  i_reset_n    in   1  asynchronous, active-low reset
//  i_clk_s      in   1  serial link clock; async to i_clk; idles high
//  i_d0_s       in   1  serial lane 0; async
//  i_d1_s       in   1  serial lane 1; async
//  o_port       out  8  last good port word
//  o_button     out  8  last good button word
//  o_link_pow   out  4  last good link-power word
//  o_valid      out  1  1-cycle strobe: outputs were just updated
//  o_frame_err  out  1  1-cycle strobe: frame discarded
//  o_locked     out  1  high after a good frame; low on error or link loss
// BEHAVIOUR
//  - Reset values: all outputs 0. State goes to HUNT. Counters clear.
//  - Inputs pass through SYNC_STAGES FFs. Rising edges of i_clk_s are detected on the
//    synchronised copy. d0/d1 are sampled on the i_clk cycle the edge is detected.
//  - Frame is 10 rising edges, MSB first:
//    d0 = {port[7:0], link_pow[3:2]}, d1 = {button[7:0], link_pow[1:0]}.
//  - Gap detection: the idle counter counts cycles with synced i_clk_s high and no edge.
//    It resets on any edge and saturates at IDLE_CYCLES. A gap is the cycle it reaches IDLE_CYCLES.
//  - States:
//    - HUNT: ignore edges; on gap -> WAIT.
//    - WAIT: on first edge -> SHIFT with bit_cnt=1.
//    - SHIFT: each edge shifts both lanes and increments bit_cnt. On gap:
//      - bit_cnt==10 -> commit: outputs update, o_valid=1, o_locked=1; -> WAIT.
//      - bit_cnt!=10 -> o_frame_err=1, o_locked=0; -> WAIT.
//    - An 11th edge in SHIFT -> o_frame_err=1, o_locked=0; -> HUNT.
//  - Latency: o_valid asserts exactly IDLE_CYCLES i_clk cycles after the 10th edge is detected.
//    Outputs change only on the o_valid cycle and hold otherwise.
//  - Link loss: a separate counter counts cycles since the last edge, saturating at LOSS_CYCLES.
//    On reaching LOSS_CYCLES: o_locked=0. Data outputs hold their last values. No o_frame_err.
//  - o_valid and o_frame_err are never high in the same cycle.
//  - Reset mid-frame: the partial frame is dropped. A full gap must be seen after reset
//    before any frame is accepted.
// CONFIGURATION
//  HOST_RX_PARITY_EN defined:
//    - Frame is 11 edges. The 11th bit on each lane is even parity over that lane's 10 data bits.
//    - Commit requires both parities correct. A parity fail gives o_frame_err=1, o_locked=0,
//      outputs unchanged, next state WAIT.
//    - The 12th edge is the overflow condition.
//  HOST_RX_PARITY_EN undefined: 10-edge frame, no parity check.
// STRUCTURE
//  - Package breakout_link_pkg holds:
//    - FRAME_BITS (10) and PORT_W/BUTTON_W/LINK_POW_W (8/8/4).
//    - The lane bit-mapping constants.
//    - The rx_state_t enum {HUNT, WAIT, SHIFT}.
//  - The serialiser reuses the package.
//  - Sub-module link_sync_edge: SYNC_STAGES synchroniser for clk_s/d0/d1 plus an
//    rising-edge strobe output. Instantiated once.
// TESTING
//  - Bench model: i_clk 50 MHz. Serial clock period 8 i_clk cycles. IDLE gap 40 cycles
//    between frames. Each case runs with HOST_RX_PARITY_EN both on and off.
//  - Reset:
//    - Hold i_reset_n=0 for 5 cycles while frames stream -> all outputs 0.
//    - The first frame after release is dropped (no gap yet seen).
//    - The second frame is accepted.
//  - Good frame: port=8'hF0, button=8'hAA, link_pow=4'b1000
//    -> one o_valid pulse with those values, o_locked=1.
//    - Then link_pow=4'b1111 -> o_link_pow=4'hF on the next o_valid.
//  - Short frame: 7 edges then gap -> o_frame_err pulse, o_locked=0, outputs hold 8'hF0/8'hAA.
//    The next good frame relocks.
//  - Long frame: 11 edges (12 with parity) -> o_frame_err.
//    No o_valid until the following gap-delimited good frame.
//  - Link loss: stop i_clk_s high for LOSS_CYCLES+10 -> o_locked falls exactly
//    LOSS_CYCLES after the last edge. No error strobe. Data held.
//  - Parity (EN only): flip the d1 parity bit -> o_frame_err, outputs unchanged.
//    Async-reset assert in mid-SHIFT -> immediate output clear.

Source files
------------

// File: rtl/breakout_link_pkg.sv
// ---------------------------------------------------------------------------
// breakout_link_pkg
// Shared definitions for the breakout serial status link (serialiser and
// host receiver): frame length, field widths, lane bit mapping and the
// receiver state type.
//
// Configuration macro: HOST_RX_PARITY_EN
//   defined   -> each lane carries an 11th bit, even parity over its 10 data bits
//   undefined -> 10-bit frame, no parity
// ---------------------------------------------------------------------------
package breakout_link_pkg;

    localparam int FRAME_BITS = 10;
    localparam int PORT_W     = 8;
    localparam int BUTTON_W   = 8;
    localparam int LINK_POW_W = 4;

`ifdef HOST_RX_PARITY_EN
    localparam int FRAME_EDGES = FRAME_BITS + 1;
`else
    localparam int FRAME_EDGES = FRAME_BITS;
`endif

    // Lane bit mapping inside the 10-bit data word (bit 9 is sent first):
    //   lane 0 = {port[7:0],   link_pow[3:2]}
    //   lane 1 = {button[7:0], link_pow[1:0]}
    localparam int LANE_WORD_MSB = 9;
    localparam int LANE_WORD_LSB = 2;
    localparam int LANE_POW_MSB  = 1;
    localparam int LANE_POW_LSB  = 0;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2
    } rx_state_t;

    // True when data bits plus trailing parity bit XOR to zero.
    function automatic logic even_parity_ok(input logic [FRAME_EDGES-1:0] lane);
        return ~(^lane);
    endfunction

endpackage

// File: rtl/link_sync_edge.sv
// ---------------------------------------------------------------------------
// link_sync_edge
// Brings the three asynchronous link wires into the host clock domain through
// SYNC_STAGES flip-flops each and flags rising edges of the serial clock.
// Data lanes go through the same depth as the clock, so on the cycle `rise`
// is high the synchronised lanes hold the bit launched with that edge.
//
// Ports
//   clk       in  host clock
//   rst_n     in  asynchronous active-low reset
//   clk_s     in  serial clock (async, idles high)
//   d0_s      in  serial lane 0 (async)
//   d1_s      in  serial lane 1 (async)
//   clk_sync  out synchronised serial clock
//   d0_sync   out synchronised lane 0
//   d1_sync   out synchronised lane 1
//   rise      out one-cycle strobe on a rising edge of clk_sync
// ---------------------------------------------------------------------------
module link_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_s,
    input  logic d0_s,
    input  logic d1_s,
    output logic clk_sync,
    output logic d0_sync,
    output logic d1_sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] clk_pipe;
    logic [SYNC_STAGES-1:0] d0_pipe;
    logic [SYNC_STAGES-1:0] d1_pipe;
    logic                   clk_prev;

    // Clock chain resets to the idle-high level so release does not fake an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_pipe <= '1;
            d0_pipe  <= '0;
            d1_pipe  <= '0;
            clk_prev <= 1'b1;
        end else begin
            clk_pipe <= {clk_pipe[SYNC_STAGES-2:0], clk_s};
            d0_pipe  <= {d0_pipe[SYNC_STAGES-2:0], d0_s};
            d1_pipe  <= {d1_pipe[SYNC_STAGES-2:0], d1_s};
            clk_prev <= clk_pipe[SYNC_STAGES-1];
        end
    end

    assign clk_sync = clk_pipe[SYNC_STAGES-1];
    assign d0_sync  = d0_pipe[SYNC_STAGES-1];
    assign d1_sync  = d1_pipe[SYNC_STAGES-1];
    assign rise     = clk_sync & ~clk_prev;

endmodule

// File: rtl/host_from_breakout.sv
// ---------------------------------------------------------------------------
// host_from_breakout
// Host-side receiver for the breakout serial status link. Oversamples the
// 3-wire link in the i_clk domain, frames on idle gaps, and presents each good
// frame as port/button/link-power words with a one-cycle valid strobe.
//
// Configuration macro: HOST_RX_PARITY_EN (11-edge frame with per-lane even
// parity; default build is a 10-edge frame without parity).
//
// Parameters
//   SYNC_STAGES  synchroniser depth (>= 2)
//   IDLE_CYCLES  high, edge-free cycles that delimit a frame (>= 2)
//   LOSS_CYCLES  edge-free cycles before lock is dropped (> IDLE_CYCLES)
// Ports
//   i_clk        in   host clock
//   i_reset_n    in   asynchronous active-low reset
//   i_clk_s      in   serial clock, async, idles high
//   i_d0_s       in   serial lane 0, async
//   i_d1_s       in   serial lane 1, async
//   o_port       out  [7:0] last good port word
//   o_button     out  [7:0] last good button word
//   o_link_pow   out  [3:0] last good link-power word
//   o_valid      out  one-cycle strobe, outputs just updated
//   o_frame_err  out  one-cycle strobe, frame discarded
//   o_locked     out  high after a good frame, low on error or link loss
// ---------------------------------------------------------------------------
module host_from_breakout
    import breakout_link_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_CYCLES = 16,
    parameter int LOSS_CYCLES = 4096
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_clk_s,
    input  logic                  i_d0_s,
    input  logic                  i_d1_s,
    output logic [PORT_W-1:0]     o_port,
    output logic [BUTTON_W-1:0]   o_button,
    output logic [LINK_POW_W-1:0] o_link_pow,
    output logic                  o_valid,
    output logic                  o_frame_err,
    output logic                  o_locked
);

    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int LOSS_W = $clog2(LOSS_CYCLES + 1);
    localparam int CNT_W  = $clog2(FRAME_EDGES + 2);

    logic clk_sync;
    logic d0_sync;
    logic d1_sync;
    logic rise;

    link_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (i_clk),
        .rst_n    (i_reset_n),
        .clk_s    (i_clk_s),
        .d0_s     (i_d0_s),
        .d1_s     (i_d1_s),
        .clk_sync (clk_sync),
        .d0_sync  (d0_sync),
        .d1_sync  (d1_sync),
        .rise     (rise)
    );

    // Gap and link-loss timing
    // Both counters load 1 on an edge so the edge cycle itself is counted; the
    // registered result of a strobe fired at count N-1 then appears exactly N
    // cycles after the edge. Strobes fire once, then the counters saturate.
    logic [IDLE_W-1:0] idle_cnt;
    logic [LOSS_W-1:0] loss_cnt;
    logic              gap;
    logic              lost;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            idle_cnt <= '0;
            loss_cnt <= '0;
        end else begin
            if (rise)
                idle_cnt <= IDLE_W'(1);
            else if (!clk_sync)
                idle_cnt <= '0;
            else if (idle_cnt != IDLE_W'(IDLE_CYCLES))
                idle_cnt <= idle_cnt + 1'b1;

            if (rise)
                loss_cnt <= LOSS_W'(1);
            else if (loss_cnt != LOSS_W'(LOSS_CYCLES))
                loss_cnt <= loss_cnt + 1'b1;
        end
    end

    assign gap  = ~rise & clk_sync & (idle_cnt == IDLE_W'(IDLE_CYCLES - 1));
    assign lost = ~rise & (loss_cnt == LOSS_W'(LOSS_CYCLES - 1));

    // Frame state machine
    rx_state_t         state;
    rx_state_t         state_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_next;
    logic              shift_en;
    logic              commit;
    logic              frame_err;
    logic              parity_ok;

    logic [FRAME_EDGES-1:0] lane0_sh;
    logic [FRAME_EDGES-1:0] lane1_sh;
    logic [FRAME_BITS-1:0]  data0;
    logic [FRAME_BITS-1:0]  data1;

    assign data0 = lane0_sh[FRAME_EDGES-1 -: FRAME_BITS];
    assign data1 = lane1_sh[FRAME_EDGES-1 -: FRAME_BITS];

`ifdef HOST_RX_PARITY_EN
    assign parity_ok = even_parity_ok(lane0_sh) & even_parity_ok(lane1_sh);
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= HUNT;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_en     = 1'b0;
        commit       = 1'b0;
        frame_err    = 1'b0;
        unique case (state)
            HUNT: begin
                if (gap)
                    state_next = WAIT;
            end
            WAIT: begin
                if (rise) begin
                    state_next   = SHIFT;
                    bit_cnt_next = CNT_W'(1);
                    shift_en     = 1'b1;
                end
            end
            SHIFT: begin
                if (rise) begin
                    if (bit_cnt == CNT_W'(FRAME_EDGES)) begin
                        // One edge too many: drop and resynchronise on a fresh gap.
                        frame_err  = 1'b1;
                        state_next = HUNT;
                    end else begin
                        shift_en     = 1'b1;
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end else if (gap) begin
                    state_next = WAIT;
                    if (bit_cnt == CNT_W'(FRAME_EDGES) && parity_ok)
                        commit = 1'b1;
                    else
                        frame_err = 1'b1;
                end
            end
            default: state_next = HUNT;
        endcase
    end

    // Lane shift registers: contents only matter once bit_cnt says a frame is complete.
    always_ff @(posedge i_clk) begin
        if (shift_en) begin
            lane0_sh <= {lane0_sh[FRAME_EDGES-2:0], d0_sync};
            lane1_sh <= {lane1_sh[FRAME_EDGES-2:0], d1_sync};
        end
    end

    // Output registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_port      <= '0;
            o_button    <= '0;
            o_link_pow  <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_locked    <= 1'b0;
        end else begin
            o_valid     <= commit;
            o_frame_err <= frame_err;
            if (commit) begin
                o_port     <= data0[LANE_WORD_MSB:LANE_WORD_LSB];
                o_button   <= data1[LANE_WORD_MSB:LANE_WORD_LSB];
                o_link_pow <= {data0[LANE_POW_MSB:LANE_POW_LSB],
                               data1[LANE_POW_MSB:LANE_POW_LSB]};
            end
            if (commit)
                o_locked <= 1'b1;
            else if (frame_err || lost)
                o_locked <= 1'b0;
        end
    end

endmodule

// File: tb/tb_host_from_breakout.sv
`timescale 1ns/1ps
module tb_host_from_breakout;

    localparam int SYNC_STAGES = 2;
    localparam int IDLE_CYCLES = 16;
    localparam int LOSS_CYCLES = 4096;
    localparam int HALF_BIT    = 4;
    localparam int GAP         = 40;
`ifdef HOST_RX_PARITY_EN
    localparam int FRAME_EDGES = 11;
`else
    localparam int FRAME_EDGES = 10;
`endif

    localparam int K_NONE    = 0;
    localparam int K_VALID   = 1;
    localparam int K_GAP_ERR = 2;
    localparam int K_OVF_ERR = 3;

    logic       i_clk     = 1'b0;
    logic       i_reset_n = 1'b1;
    logic       i_clk_s   = 1'b1;
    logic       i_d0_s    = 1'b0;
    logic       i_d1_s    = 1'b0;
    logic [7:0] o_port;
    logic [7:0] o_button;
    logic [3:0] o_link_pow;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_locked;

    host_from_breakout #(
        .SYNC_STAGES (SYNC_STAGES),
        .IDLE_CYCLES (IDLE_CYCLES),
        .LOSS_CYCLES (LOSS_CYCLES)
    ) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_clk_s     (i_clk_s),
        .i_d0_s      (i_d0_s),
        .i_d1_s      (i_d1_s),
        .o_port      (o_port),
        .o_button    (o_button),
        .o_link_pow  (o_link_pow),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_locked    (o_locked)
    );

    always #10 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;   // 1 = valid, 2 = frame error
        logic [7:0] port;
        logic [7:0] button;
        logic [3:0] pow;
        int         due;
    } exp_t;

    exp_t sb[$];

    // Last committed words as the receiver should hold them.
    logic [7:0] m_port   = 8'h00;
    logic [7:0] m_button = 8'h00;
    logic [3:0] m_pow    = 4'h0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Sends one frame MSB first, clock low then high for HALF_BIT cycles each,
    // followed by an idle-high gap. The expectation is queued at the last edge.
    task automatic send_frame(input logic [7:0] port, input logic [7:0] button,
                              input logic [3:0] pow, input int n_edges,
                              input bit flip_par, input int kind, output int last);
        logic [9:0]  w0;
        logic [9:0]  w1;
        logic [11:0] l0;
        logic [11:0] l1;
        exp_t        e;
        w0 = {port, pow[3:2]};
        w1 = {button, pow[1:0]};
        l0 = {w0, 2'b00};
        l1 = {w1, 2'b00};
`ifdef HOST_RX_PARITY_EN
        l0[1] = ^w0;
        l1[1] = (^w1) ^ flip_par;
`else
        if (flip_par) l1[1] = 1'b1;  // no parity bit in this build; trailing bit unused
`endif
        last = cyc;
        for (int i = 0; i < n_edges; i++) begin
            tick(1);
            i_clk_s = 1'b0;
            i_d0_s  = l0[11-i];
            i_d1_s  = l1[11-i];
            tick(HALF_BIT);
            i_clk_s = 1'b1;
            last    = cyc;
            if (i == n_edges - 1 && kind != K_NONE) begin
                if (kind == K_VALID) begin
                    m_port   = port;
                    m_button = button;
                    m_pow    = pow;
                    e.kind   = 1;
                    e.due    = last + SYNC_STAGES + IDLE_CYCLES;
                end else begin
                    e.kind = 2;
                    e.due  = (kind == K_OVF_ERR) ? last + SYNC_STAGES + 1
                                                 : last + SYNC_STAGES + IDLE_CYCLES;
                end
                e.port   = m_port;
                e.button = m_button;
                e.pow    = m_pow;
                sb.push_back(e);
            end
            tick(HALF_BIT - 1);
        end
        tick(GAP);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_port"},   32'(o_port),      32'h0);
        chk({tag, "_button"}, 32'(o_button),    32'h0);
        chk({tag, "_pow"},    32'(o_link_pow),  32'h0);
        chk({tag, "_valid"},  32'(o_valid),     32'h0);
        chk({tag, "_err"},    32'(o_frame_err), 32'h0);
        chk({tag, "_locked"}, 32'(o_locked),    32'h0);
    endtask

    task automatic check_held(input string tag);
        chk({tag, "_port"},   32'(o_port),     32'(m_port));
        chk({tag, "_button"}, 32'(o_button),   32'(m_button));
        chk({tag, "_pow"},    32'(o_link_pow), 32'(m_pow));
    endtask

    // Scoreboard: every strobe must match the next queued expectation.
    exp_t got_e;
    always @(negedge i_clk) begin
        if (i_reset_n && (o_valid || o_frame_err)) begin
            if (o_valid && o_frame_err)
                chk("valid_and_err_same_cycle", 32'd1, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {30'd0, o_valid, o_frame_err}, 32'd0);
            end else begin
                got_e = sb.pop_front();
                chk("strobe_kind",  o_valid ? 32'd1 : 32'd2, 32'(got_e.kind));
                chk("strobe_cycle", 32'(cyc), 32'(got_e.due));
                chk("port",         32'(o_port),     32'(got_e.port));
                chk("button",       32'(o_button),   32'(got_e.button));
                chk("link_pow",     32'(o_link_pow), 32'(got_e.pow));
                chk("locked",       32'(o_locked),   (got_e.kind == 1) ? 32'd1 : 32'd0);
            end
        end
    end

    initial begin
        #(20 * 30000);
        $display("FAIL watchdog: cycle %0d reached, required finish before 30000", cyc);
        $fatal(1, "watchdog");
    end

    int last;
    int last_e;

    initial begin
        #1 i_reset_n = 1'b0;

        // Reset held while a frame streams; release mid-frame drops that frame.
        fork
            send_frame(8'h5A, 8'h3C, 4'h9, FRAME_EDGES, 1'b0, K_NONE, last);
            begin
                tick(3);
                check_all_zero("reset");
                tick(2);
                i_reset_n = 1'b1;
            end
        join
        chk("after_reset_drop_drain", 32'(sb.size()), 32'd0);

        // Good frames
        send_frame(8'hF0, 8'hAA, 4'b1000, FRAME_EDGES, 1'b0, K_VALID, last);
        chk("good1_drain", 32'(sb.size()), 32'd0);
        chk("good1_locked", 32'(o_locked), 32'd1);
        send_frame(8'hF0, 8'hAA, 4'b1111, FRAME_EDGES, 1'b0, K_VALID, last);
        chk("good2_drain", 32'(sb.size()), 32'd0);

        // Short frame
        send_frame(8'h11, 8'h22, 4'h3, 7, 1'b0, K_GAP_ERR, last);
        chk("short_drain", 32'(sb.size()), 32'd0);
        chk("short_locked", 32'(o_locked), 32'd0);
        check_held("short_hold");
        send_frame(8'h3C, 8'h5A, 4'h6, FRAME_EDGES, 1'b0, K_VALID, last);
        chk("relock_locked", 32'(o_locked), 32'd1);

        // Long frame, then the next delimited good frame
        send_frame(8'h77, 8'h88, 4'h1, FRAME_EDGES + 1, 1'b0, K_OVF_ERR, last);
        chk("long_drain", 32'(sb.size()), 32'd0);
        chk("long_locked", 32'(o_locked), 32'd0);
        check_held("long_hold");
        send_frame(8'hC3, 8'hA5, 4'h2, FRAME_EDGES, 1'b0, K_VALID, last);
        chk("after_long_drain", 32'(sb.size()), 32'd0);

`ifdef HOST_RX_PARITY_EN
        // Corrupted lane-1 parity
        send_frame(8'h12, 8'h34, 4'h5, FRAME_EDGES, 1'b1, K_GAP_ERR, last);
        chk("parity_drain", 32'(sb.size()), 32'd0);
        chk("parity_locked", 32'(o_locked), 32'd0);
        check_held("parity_hold");
`endif

        // Link loss after a good frame
        send_frame(8'h81, 8'h42, 4'hF, FRAME_EDGES, 1'b0, K_VALID, last_e);
        chk("pre_loss_drain", 32'(sb.size()), 32'd0);
        while (cyc < last_e + SYNC_STAGES + LOSS_CYCLES - 1) tick(1);
        chk("loss_locked_before", 32'(o_locked), 32'd1);
        tick(1);
        chk("loss_locked_after", 32'(o_locked), 32'd0);
        check_held("loss_hold");
        tick(10);
        chk("loss_locked_stays", 32'(o_locked), 32'd0);

        // Relock, then asynchronous reset in the middle of a frame
        send_frame(8'h0F, 8'hF0, 4'hA, FRAME_EDGES, 1'b0, K_VALID, last);
        chk("relock2_locked", 32'(o_locked), 32'd1);
        fork
            send_frame(8'h55, 8'h66, 4'h7, FRAME_EDGES, 1'b0, K_NONE, last);
            begin
                tick(30);
                #3 i_reset_n = 1'b0;
                #1 check_all_zero("async_reset");
                m_port   = 8'h00;
                m_button = 8'h00;
                m_pow    = 4'h0;
                tick(3);
                i_reset_n = 1'b1;
            end
        join
        send_frame(8'h9C, 8'h63, 4'h4, FRAME_EDGES, 1'b0, K_VALID, last);

        tick(20);
        chk("final_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
